driver_complex_multiplier: RTL and testbench

//  Stimulus driver for the complex multiplier: the initiator end of the op_*/res_* handshakes.

---
 rtl/driver_complex_multiplier.sv | 267 ++++++++++++++++++++++++++
 tb/tb_driver_complex_multiplier.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/driver_complex_multiplier.sv
// ---------------------------------------------------------------------------
// driver_complex_multiplier
//
// Purpose:
//   Initiator end of the complex-multiplier op_*/res_* handshakes. Operand
//   words come from a 32-bit Galois LFSR. They are offered on op_val/op_data,
//   and results are accepted through res_ready. Exactly one transaction is
//   ever outstanding, so a passive checker on the same pins can pair every
//   result with the most recent operand.
//
// Ports:
//   clk        in   1                rising-edge clock
//   rst        in   1                asynchronous reset, active-high
//   sw_rst     in   1                synchronous soft reset, active-high
//   start      in   1                run request pulse (honoured in IDLE/DONE)
//   op_val     out  1                operand valid
//   op_ready   in   1                multiplier accepts operand
//   op_data    out  4*DATA_WIDTH     {a,b,c,d} for (a+jb)*(c+jd)
//   res_val    in   1                multiplier result valid
//   res_ready  out  1                driver accepts result
//   res_data   in   4*DATA_WIDTH+4   result word (used for the handshake only)
//   busy       out  1                run in progress
//   done       out  1                run finished (sticky until next start)
//   timeout    out  1                run aborted waiting for a result (sticky)
//   op_cnt     out  CW               accepted operands, CW=$clog2(NUM_OPS+1)
//   res_cnt    out  CW               accepted results
//
// Configuration:
//   DRV_RANDOM_STALL_EN - when defined, res_ready in WAIT_RES is further gated
//   by bit 0 of a free-running 16-bit stall LFSR. This exercises back-pressure
//   on the result channel. When it is undefined, res_ready is deterministic
//   and no stall generator is built.
// ---------------------------------------------------------------------------
module driver_complex_multiplier #(
  parameter int          DATA_WIDTH = 8,
  parameter int          NUM_OPS    = 16,
  parameter logic [31:0] SEED       = 32'h0403_0201,
  parameter int          IDLE_GAP   = 0,
  parameter int          RES_DELAY  = 0,
  parameter int          TIMEOUT    = 64
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              sw_rst,
  input  logic                              start,
  output logic                              op_val,
  input  logic                              op_ready,
  output logic [4*DATA_WIDTH-1:0]           op_data,
  input  logic                              res_val,
  output logic                              res_ready,
  input  logic [4*DATA_WIDTH+3:0]           res_data,
  output logic                              busy,
  output logic                              done,
  output logic                              timeout,
  output logic [$clog2(NUM_OPS+1)-1:0]      op_cnt,
  output logic [$clog2(NUM_OPS+1)-1:0]      res_cnt
);

  localparam int OW = 4 * DATA_WIDTH;
  localparam int CW = $clog2(NUM_OPS + 1);
  // The wait counter only has to reach TIMEOUT-1. Its +1 look-ahead reaches TIMEOUT.
  localparam int WW = $clog2(TIMEOUT + 1);
  // Keep at least one bit, even when IDLE_GAP is zero and the gap state is never used.
  localparam int GW = $clog2(IDLE_GAP + 2);

  localparam logic [31:0] LFSR_MASK    = 32'h8020_0003;
  localparam bit          RDY_AT_ENTRY = (RES_DELAY == 0);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_GAP      = 3'd1,
    S_SEND     = 3'd2,
    S_WAIT_RES = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  // One Galois right-shift step of the operand generator.
  function automatic logic [31:0] lfsr32_step(input logic [31:0] v);
    lfsr32_step = (v >> 1) ^ (v[0] ? LFSR_MASK : 32'h0000_0000);
  endfunction

  // Transaction counters stop at NUM_OPS instead of wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    if (int'(v) < NUM_OPS) begin
      sat_inc = v + CW'(1);
    end else begin
      sat_inc = v;
    end
  endfunction

  state_t          state_r;
  logic [31:0]     lfsr_r;
  logic [WW-1:0]   wait_cnt_r;
  logic [GW-1:0]   gap_cnt_r;

  logic [31:0]     lfsr_next_s;
  logic [WW-1:0]   wait_next_s;
  logic            op_hs_s;
  logic            res_hs_s;
  logic            rdy_next_s;
  logic            last_res_s;
  logic            wait_expired_s;
  logic            gap_last_s;
  logic            grant_next_s;

  // The result payload belongs to the checker. Only its handshake matters here.
  logic            unused_res_s;
  assign unused_res_s = ^res_data;

`ifdef DRV_RANDOM_STALL_EN
  localparam logic [15:0] STALL_SEED = 16'hACE1;
  localparam logic [15:0] STALL_MASK = 16'hB400;

  logic [15:0] stall_lfsr_r;
  logic [15:0] stall_next_s;

  function automatic logic [15:0] lfsr16_step(input logic [15:0] v);
    lfsr16_step = (v >> 1) ^ (v[0] ? STALL_MASK : 16'h0000);
  endfunction

  assign stall_next_s = lfsr16_step(stall_lfsr_r);
  // res_ready is registered, so it is gated with the value the stall LFSR holds during the next cycle.
  assign grant_next_s = stall_next_s[0];

  // Free-running stall generator. It steps every cycle and restarts on either reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_lfsr_r <= STALL_SEED;
    end else if (sw_rst) begin
      stall_lfsr_r <= STALL_SEED;
    end else begin
      stall_lfsr_r <= stall_next_s;
    end
  end
`else
  assign grant_next_s = 1'b1;
`endif

  // Handshake detection and look-ahead terms for the registered outputs.
  always_comb begin
    lfsr_next_s    = lfsr32_step(lfsr_r);
    op_hs_s        = (state_r == S_SEND) && op_val && op_ready;
    res_hs_s       = (state_r == S_WAIT_RES) && res_val && res_ready;
    wait_next_s    = wait_cnt_r + WW'(1);
    // res_ready for the coming cycle reflects the count that cycle will hold.
    rdy_next_s     = (int'(wait_next_s) >= RES_DELAY) && grant_next_s;
    last_res_s     = (int'(res_cnt) >= NUM_OPS - 1);
    wait_expired_s = (int'(wait_cnt_r) >= TIMEOUT - 1);
    gap_last_s     = (int'(gap_cnt_r) >= IDLE_GAP - 1);
  end

  // Run-control FSM. Every handshake output and status flag is driven from here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= S_IDLE;
      lfsr_r     <= SEED;
      wait_cnt_r <= WW'(0);
      gap_cnt_r  <= GW'(0);
      op_val     <= 1'b0;
      op_data    <= OW'(0);
      res_ready  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      op_cnt     <= CW'(0);
      res_cnt    <= CW'(0);
    end else if (sw_rst) begin
      // The soft reset takes priority over start and over any handshake in the same cycle.
      state_r    <= S_IDLE;
      lfsr_r     <= SEED;
      wait_cnt_r <= WW'(0);
      gap_cnt_r  <= GW'(0);
      op_val     <= 1'b0;
      op_data    <= OW'(0);
      res_ready  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      op_cnt     <= CW'(0);
      res_cnt    <= CW'(0);
    end else begin
      case (state_r)
        S_IDLE, S_DONE: begin
          if (start) begin
            // A new run continues the operand sequence. The LFSR is not reseeded.
            op_cnt  <= CW'(0);
            res_cnt <= CW'(0);
            done    <= 1'b0;
            timeout <= 1'b0;
            busy    <= 1'b1;
            if (IDLE_GAP == 0) begin
              state_r <= S_SEND;
              op_val  <= 1'b1;
              op_data <= lfsr_r[OW-1:0];
            end else begin
              state_r   <= S_GAP;
              gap_cnt_r <= GW'(0);
            end
          end else begin
            state_r <= state_r;
          end
        end

        S_GAP: begin
          if (gap_last_s) begin
            state_r <= S_SEND;
            op_val  <= 1'b1;
            op_data <= lfsr_r[OW-1:0];
          end else begin
            gap_cnt_r <= gap_cnt_r + GW'(1);
          end
        end

        S_SEND: begin
          // op_data stays untouched here, so it is stable until the operand is taken.
          if (op_hs_s) begin
            op_val     <= 1'b0;
            op_cnt     <= sat_inc(op_cnt);
            lfsr_r     <= lfsr_next_s;
            state_r    <= S_WAIT_RES;
            wait_cnt_r <= WW'(0);
            res_ready  <= RDY_AT_ENTRY && grant_next_s;
          end else begin
            op_val <= 1'b1;
          end
        end

        S_WAIT_RES: begin
          if (res_hs_s) begin
            res_ready <= 1'b0;
            res_cnt   <= sat_inc(res_cnt);
            if (last_res_s) begin
              state_r <= S_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else if (IDLE_GAP == 0) begin
              state_r <= S_SEND;
              op_val  <= 1'b1;
              op_data <= lfsr_r[OW-1:0];
            end else begin
              state_r   <= S_GAP;
              gap_cnt_r <= GW'(0);
            end
          end else if (wait_expired_s) begin
            // No result arrived within TIMEOUT cycles of entering WAIT_RES.
            res_ready <= 1'b0;
            timeout   <= 1'b1;
            done      <= 1'b1;
            busy      <= 1'b0;
            state_r   <= S_DONE;
          end else begin
            wait_cnt_r <= wait_next_s;
            res_ready  <= rdy_next_s;
          end
        end

        default: begin
          state_r   <= S_IDLE;
          op_val    <= 1'b0;
          res_ready <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_driver_complex_multiplier.sv
// ---------------------------------------------------------------------------
// tb_driver_complex_multiplier
//
// Purpose:
//   Self-checking bench for driver_complex_multiplier. It plays the role of
//   the multiplier with randomised operand acceptance and result latency. It
//   compares the driver against a transaction-level reference that holds the
//   expected operand sequence, the transaction counts and the required timing
//   of res_ready and timeout.
//   The DUT is built with NUM_OPS=4, IDLE_GAP=0, RES_DELAY=3 and TIMEOUT=64.
// ---------------------------------------------------------------------------
module tb_driver_complex_multiplier;

  localparam int          DW   = 8;
  localparam int          NOPS = 4;
  localparam int          GAP  = 0;
  localparam int          RDLY = 3;
  localparam int          TMO  = 64;
  localparam logic [31:0] SEED = 32'h0403_0201;
  localparam int          OW   = 4 * DW;
  localparam int          CW   = $clog2(NOPS + 1);
  localparam int          RUN_BUDGET = 500;

  logic          clk = 1'b0;
  logic          rst;
  logic          sw_rst;
  logic          start;
  logic          op_val;
  logic          op_ready;
  logic [OW-1:0] op_data;
  logic          res_val;
  logic          res_ready;
  logic [OW+3:0] res_data;
  logic          busy;
  logic          done;
  logic          timeout;
  logic [CW-1:0] op_cnt;
  logic [CW-1:0] res_cnt;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [31:0]   model_lfsr;
  logic [OW-1:0] first_data;
  int            re_v;
  int            im_v;

  always #5 clk = ~clk;

  driver_complex_multiplier #(
    .DATA_WIDTH (DW),
    .NUM_OPS    (NOPS),
    .SEED       (SEED),
    .IDLE_GAP   (GAP),
    .RES_DELAY  (RDLY),
    .TIMEOUT    (TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sw_rst    (sw_rst),
    .start     (start),
    .op_val    (op_val),
    .op_ready  (op_ready),
    .op_data   (op_data),
    .res_val   (res_val),
    .res_ready (res_ready),
    .res_data  (res_data),
    .busy      (busy),
    .done      (done),
    .timeout   (timeout),
    .op_cnt    (op_cnt),
    .res_cnt   (res_cnt)
  );

  // Reference operand sequence: Galois right shift with mask 0x80200003.
  function automatic logic [31:0] lfsr_adv(input logic [31:0] v);
    lfsr_adv = (v >> 1) ^ (v[0] ? 32'h8020_0003 : 32'h0000_0000);
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Step one clock and sample just after the edge. res_data is noise that the DUT ignores.
  task automatic tick();
    @(posedge clk);
    #1;
    res_data = {4'($urandom), $urandom};
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {op_val, res_ready, busy, done, timeout}, 5'b00000);
    check({tag, "_cnt"}, {op_cnt, res_cnt}, '0);
    check({tag, "_data"}, op_data, '0);
  endtask

  // One complete run. The bench acts as the multiplier.
  task automatic do_run(input bit rand_mode, input bit hold_first, output logic [OW-1:0] first);
    int k;
    int lat;
    int hold;
    int budget;
    int exp_ops;
    int exp_res;
    bit fin;
    bit in_wait;
    bit hs_op;
    bit hs_res;
    start = 1'b1;
    tick();
    start = 1'b0;
    first = op_data;
    check("start_busy", busy, 1'b1);
    check("start_op_val", op_val, 1'b1);
    check("start_cnts", {op_cnt, res_cnt}, '0);
    check("start_flags", {done, timeout}, 2'b00);
    k = 0; lat = 0; budget = 0; exp_ops = 0; exp_res = 0;
    hold = hold_first ? 10 : 0;
    fin = 1'b0; in_wait = 1'b0;
    while (!fin && budget < RUN_BUDGET) begin
      hs_op = 1'b0; hs_res = 1'b0; op_ready = 1'b0; res_val = 1'b0;
      // A start during a run must be ignored.
      start = rand_mode ? ($urandom_range(0, 7) == 0) : 1'b0;
      if (!in_wait) begin
        check("send_op_val", op_val, 1'b1);
        check("send_data", op_data, model_lfsr[OW-1:0]);
        if (hold > 0) begin
          check("hold_op_cnt", op_cnt, exp_ops);
          hold--;
        end else begin
          op_ready = rand_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
          hs_op = op_ready && op_val;
        end
      end else begin
        check("wait_op_val", op_val, 1'b0);
`ifdef DRV_RANDOM_STALL_EN
        check("rdy_early", res_ready && (k < RDLY), 1'b0);
`else
        check("rdy_time", res_ready, k >= RDLY);
`endif
        res_val = (k >= lat);
        hs_res = res_val && res_ready;
      end
      tick();
      budget++;
      if (hs_op) begin
        model_lfsr = lfsr_adv(model_lfsr);
        exp_ops++;
        in_wait = 1'b1;
        k = 0;
        lat = rand_mode ? int'($urandom_range(0, 6)) : 2;
        check("op_cnt", op_cnt, exp_ops);
      end else if (hs_res) begin
        exp_res++;
        check("res_cnt", res_cnt, exp_res);
        if (exp_res == NOPS) fin = 1'b1;
        else in_wait = 1'b0;
      end else if (in_wait) begin
        k++;
      end
    end
    start = 1'b0; op_ready = 1'b0; res_val = 1'b0;
    check("run_finished", fin, 1'b1);
    check("end_done_busy", {done, busy, timeout}, 3'b100);
    check("end_op_cnt", op_cnt, NOPS);
    check("end_res_cnt", res_cnt, NOPS);
    check("end_handshakes", {op_val, res_ready}, 2'b00);
  endtask

  initial begin
    rst = 1'b1; sw_rst = 1'b0; start = 1'b0; op_ready = 1'b0; res_val = 1'b0;
    res_data = '0;
    model_lfsr = SEED;
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;
    repeat (5) tick();
    check_all_zero("idle");

    // First run: deterministic responder with the result 2 cycles after the operand is accepted.
    do_run(1'b0, 1'b0, first_data);
    check("first_data", first_data, 32'h0403_0201);
    re_v = int'(first_data[31:24]) * int'(first_data[15:8]) - int'(first_data[23:16]) * int'(first_data[7:0]);
    im_v = int'(first_data[31:24]) * int'(first_data[7:0]) + int'(first_data[23:16]) * int'(first_data[15:8]);
    check("first_re", re_v, 5);
    check("first_im", im_v, 10);

    // Operand back-pressure: op_ready is held low for 10 cycles in SEND.
    do_run(1'b0, 1'b1, first_data);

    // No result ever arrives, so the run times out.
    start = 1'b1; tick(); start = 1'b0;
    check("to_data", op_data, model_lfsr[OW-1:0]);
    op_ready = 1'b1; tick(); op_ready = 1'b0;
    model_lfsr = lfsr_adv(model_lfsr);
    check("to_op_cnt", op_cnt, 1);
    for (int i = 0; i < TMO - 1; i++) tick();
    check("to_not_yet", {timeout, done, busy}, 3'b001);
    tick();
    check("to_flags", {timeout, done, busy}, 3'b110);
    check("to_cnts", {op_cnt, res_cnt}, {CW'(1), CW'(0)});
    check("to_res_ready", res_ready, 1'b0);

    // Randomised runs. Each continues the operand sequence without reseeding.
    for (int r = 0; r < 3; r++) do_run(1'b1, 1'b0, first_data);

    // Soft reset in WAIT_RES, asserted in the same cycle as a result offer.
    start = 1'b1; tick(); start = 1'b0;
    op_ready = 1'b1; tick(); op_ready = 1'b0;
    model_lfsr = lfsr_adv(model_lfsr);
    repeat (4) tick();
    res_val = 1'b1; sw_rst = 1'b1;
    tick();
    sw_rst = 1'b0; res_val = 1'b0;
    check_all_zero("swrst");
    model_lfsr = SEED;
    do_run(1'b0, 1'b0, first_data);
    check("swrst_reissue", first_data, 32'h0403_0201);

    // Asynchronous reset in mid-run, checked before the next clock edge.
    start = 1'b1; tick(); start = 1'b0;
    op_ready = 1'b1; tick(); op_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_all_zero("arst");
    tick();
    rst = 1'b0;
    model_lfsr = SEED;
    do_run(1'b1, 1'b0, first_data);
    check("arst_reissue", first_data, 32'h0403_0201);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Hard stop in case a run never terminates.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
